// File: rtl/trace_seq_pkg.sv
// Shared types and defaults for the trace sequencer: FSM state encoding and default sizes.
package trace_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RESET = 3'd1,
    SHIFT = 3'd2,
    TAIL  = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

  localparam int TRACE_W_DEF = 7;
  localparam int NFSM_DEF    = 3;

endpackage

// File: rtl/trace_sequencer_chk.sv
// Property checker for trace_sequencer: the bit counter must stay below TRACE_W while shifting.
module trace_sequencer_chk
  import trace_seq_pkg::*;
#(
  parameter int TRACE_W = 7,
  parameter int CW      = 3
) (
  input logic          clk,
  input logic          rst,
  input seq_state_t    state,
  input logic [CW-1:0] cnt
);

  cnt_in_range: assert property (@(posedge clk) disable iff (rst)
    (state == SHIFT) |-> (cnt < CW'(TRACE_W)));

endmodule

// File: rtl/trace_shreg.sv
// Parallel-in / serial-out trace register: load a whole trace, shift right, expose bit 0.
module trace_shreg #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         bit0
);

  logic [W-1:0] sh_q;
  logic [W-1:0] sh_d;

  // Next contents: load wins over shift; zeros fill from the top.
  always_comb begin
    sh_d = sh_q;
    if (load) begin
      sh_d = din;
    end else if (shift) begin
      sh_d = sh_q >> 1;
    end else begin
      sh_d = sh_q;
    end
  end

  // Storage with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign bit0 = sh_q[0];

endmodule

// File: rtl/trace_sequencer.sv
// Drives a serial trace into a bank of FSMs after resetting them and collects their
// per-bit outputs into one packed response returned over valid/ready.
module trace_sequencer
  import trace_seq_pkg::*;
#(
  parameter int TRACE_W    = TRACE_W_DEF,
  parameter int NFSM       = NFSM_DEF,
  parameter int RST_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [TRACE_W-1:0]      trace_data,
  input  logic                    trace_valid,
  output logic                    trace_ready,
  output logic                    fsm_rst,
  output logic                    in,
  input  logic [NFSM-1:0]         fsm_out,
  output logic [NFSM*TRACE_W-1:0] result,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic                    busy
);

  localparam int CW  = $clog2(TRACE_W + 1);
  localparam int RCW = $clog2(RST_CYCLES + 1);

  seq_state_t             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [RCW-1:0]         rcnt_q, rcnt_d;
  logic [NFSM*TRACE_W-1:0] result_q, result_d;
  logic                   fsm_rst_q, fsm_rst_d;
  logic                   in_q, in_d;
  logic                   trace_ready_q, trace_ready_d;
  logic                   result_valid_q, result_valid_d;
  logic                   busy_q, busy_d;

  logic                   load_s, shift_s, capture_s, clear_s, sh_bit0_s;
  logic [CW-1:0]          slot_s;

  trace_shreg #(.W(TRACE_W)) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (load_s),
    .shift (shift_s),
    .din   (trace_data),
    .bit0  (sh_bit0_s)
  );

  // Sequencing FSM. fsm_out during SHIFT cycle k reflects bit k-1, so capture lags by one slot.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rcnt_d    = rcnt_q;
    load_s    = 1'b0;
    clear_s   = 1'b0;
    capture_s = 1'b0;
    slot_s    = '0;
    case (state_q)
      IDLE: begin
        if (trace_valid && trace_ready_q) begin
          load_s  = 1'b1;
          clear_s = 1'b1;
          cnt_d   = '0;
          rcnt_d  = '0;
          state_d = RESET;
        end else begin
          state_d = IDLE;
        end
      end
      RESET: begin
        if (rcnt_q == RCW'(RST_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          rcnt_d  = rcnt_q + RCW'(1);
        end
      end
      SHIFT: begin
        capture_s = (cnt_q != '0);
        slot_s    = cnt_q - CW'(1);
        if (cnt_q == CW'(TRACE_W - 1)) begin
          state_d = TAIL;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      TAIL: begin
        capture_s = 1'b1;
        slot_s    = CW'(TRACE_W - 1);
        state_d   = DONE;
      end
      DONE: begin
        if (result_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Capture array: write the addressed slot, clear everything on a new accept.
  always_comb begin
    result_d = result_q;
    for (int s = 0; s < TRACE_W; s++) begin
      if (capture_s && (slot_s == CW'(s))) begin
        result_d[s*NFSM +: NFSM] = fsm_out;
      end else if (clear_s) begin
        result_d[s*NFSM +: NFSM] = '0;
      end else begin
        result_d[s*NFSM +: NFSM] = result_q[s*NFSM +: NFSM];
      end
    end
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_comb begin
    shift_s        = (state_d == SHIFT);
    fsm_rst_d      = (state_d == RESET);
    in_d           = shift_s ? sh_bit0_s : 1'b0;
    trace_ready_d  = (state_d == IDLE);
    result_valid_d = (state_d == DONE);
    busy_d         = (state_d != IDLE);
  end

  // State and registered outputs; reset holds the downstream FSMs in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      rcnt_q         <= '0;
      result_q       <= '0;
      fsm_rst_q      <= 1'b1;
      in_q           <= 1'b0;
      trace_ready_q  <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rcnt_q         <= rcnt_d;
      result_q       <= result_d;
      fsm_rst_q      <= fsm_rst_d;
      in_q           <= in_d;
      trace_ready_q  <= trace_ready_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign trace_ready  = trace_ready_q;
  assign fsm_rst      = fsm_rst_q;
  assign in           = in_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;

  trace_sequencer_chk #(.TRACE_W(TRACE_W), .CW(CW)) u_chk (
    .clk   (clk),
    .rst   (rst),
    .state (state_q),
    .cnt   (cnt_q)
  );

endmodule

// File: tb/tb_trace_sequencer.sv
// Scoreboard bench for trace_sequencer driving three identical registered-echo stub FSMs.
module tb_trace_sequencer;

  localparam int TW = 7;
  localparam int NF = 3;
  localparam int RW = NF * TW;

  logic          clk = 1'b0;
  logic          rst;
  logic [TW-1:0] trace_data;
  logic          trace_valid;
  logic          trace_ready;
  logic          fsm_rst;
  logic          fsm_in;
  logic [NF-1:0] fsm_out;
  logic [RW-1:0] result;
  logic          result_valid;
  logic          result_ready;
  logic          busy;

  logic          stub_q;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] mon_exp;
  int            total = 0;
  int            bad   = 0;

  always #5 clk = ~clk;

  trace_sequencer #(.TRACE_W(TW), .NFSM(NF), .RST_CYCLES(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .trace_data   (trace_data),
    .trace_valid  (trace_valid),
    .trace_ready  (trace_ready),
    .fsm_rst      (fsm_rst),
    .in           (fsm_in),
    .fsm_out      (fsm_out),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy)
  );

  // Stub FSM: registered echo, cleared by fsm_rst.
  always @(posedge clk) begin
    if (fsm_rst) stub_q <= 1'b0;
    else         stub_q <= fsm_in;
  end
  assign fsm_out = {NF{stub_q}};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every completed result handshake is compared with the scoreboard head.
  always @(negedge clk) begin
    if (result_valid === 1'b1 && result_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got %0h expected none", result);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", 32'(result), 32'(mon_exp));
      end
    end
  end

  task automatic do_trace(input logic [TW-1:0] d, input logic [RW-1:0] exp, input int hold);
    logic [TW-1:0] sh;
    int w;
    w = 0;
    while (trace_ready !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    check("ready_before_accept", 32'(trace_ready), 32'd1);
    trace_data   = d;
    trace_valid  = 1'b1;
    result_ready = (hold == 0);
    exp_q.push_back(exp);
    tick();
    check("fsm_rst_pulse", 32'(fsm_rst), 32'd1);
    check("busy_on", 32'(busy), 32'd1);
    check("ready_drop", 32'(trace_ready), 32'd0);
    check("in_low_reset", 32'(fsm_in), 32'd0);
    trace_valid = 1'b0;
    trace_data  = ~d;
    sh = d;
    for (int n = 1; n <= 9; n++) begin
      tick();
      check("in_bit", 32'(fsm_in), 32'(sh[0]));
      sh = sh >> 1;
      check("fsm_rst_low", 32'(fsm_rst), 32'd0);
      check("valid_latency", 32'(result_valid), 32'(n == 9));
    end
    if (hold > 0) begin
      trace_valid = 1'b1;
      trace_data  = 7'h55;
      for (int h = 0; h < hold; h++) begin
        check("hold_valid", 32'(result_valid), 32'd1);
        check("hold_result", 32'(result), 32'(exp));
        check("hold_no_ready", 32'(trace_ready), 32'd0);
        tick();
      end
      result_ready = 1'b1;
      tick();
      check("idle_ready", 32'(trace_ready), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);
      trace_valid = 1'b0;
      tick();
      check("no_accept_in_done", 32'(busy), 32'd0);
    end else begin
      tick();
      check("idle_ready", 32'(trace_ready), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_valid", 32'(result_valid), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  gap;
    bit  found;
    logic r;
    rst          = 1'b1;
    trace_valid  = 1'b0;
    trace_data   = '0;
    result_ready = 1'b1;
    tick(); tick(); tick();
    check("rst_fsm_rst", 32'(fsm_rst), 32'd1);
    check("rst_in", 32'(fsm_in), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(trace_ready), 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_fsm_rst", 32'(fsm_rst), 32'd0);
    check("post_rst_ready", 32'(trace_ready), 32'd1);

    // 1: alternating bits
    do_trace(7'b1010101, 21'h1C71C7, 0);
    // 2: all zeros
    do_trace(7'b0000000, 21'h000000, 0);
    // 3: consumer stalls for 5 cycles in DONE
    do_trace(7'b0110010, 21'h03F038, 5);

    // 4: reset during SHIFT cycle 3 aborts the trace
    trace_data  = 7'h7F;
    trace_valid = 1'b1;
    tick();
    trace_valid = 1'b0;
    for (int n = 1; n <= 4; n++) tick();
    check("abort_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    check("abort_fsm_rst", 32'(fsm_rst), 32'd1);
    check("abort_result", 32'(result), 32'd0);
    check("abort_valid", 32'(result_valid), 32'd0);
    check("abort_busy_low", 32'(busy), 32'd0);
    check("abort_in", 32'(fsm_in), 32'd0);
    rst = 1'b0;
    tick();
    check("abort_ready", 32'(trace_ready), 32'd1);
    do_trace(7'b0001011, 21'h000E3F, 0);

    // 5: back-to-back with trace_valid and result_ready tied high
    trace_data   = 7'h7F;
    trace_valid  = 1'b1;
    result_ready = 1'b1;
    exp_q.push_back(21'h1FFFFF);
    tick();
    trace_data = 7'h01;
    exp_q.push_back(21'h000007);
    gap   = 0;
    found = 1'b0;
    for (int i = 1; i <= 20 && !found; i++) begin
      r = trace_ready;
      tick();
      if (r === 1'b1) begin
        found = 1'b1;
        gap   = i;
      end
    end
    check("b2b_gap", 32'(gap), 32'd11);
    trace_valid = 1'b0;
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick();
    tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
